// File: rtl/cu_setup_control_pkg.sv
// Shared types for the compute-unit setup sequencer: one-hot state encoding,
// request record and a busy-state helper.
package PKG_SETUP;

  localparam int CU_SETUP_STATE_W = 10;
  localparam int CU_SETUP_ADDR_MAX_W = 64;

  typedef enum logic [CU_SETUP_STATE_W-1:0] {
    CU_SETUP_RESET       = 10'b00_0000_0001,
    CU_SETUP_IDLE        = 10'b00_0000_0010,
    CU_SETUP_REQ_START   = 10'b00_0000_0100,
    CU_SETUP_REQ_BUSY    = 10'b00_0000_1000,
    CU_SETUP_REQ_PAUSE   = 10'b00_0001_0000,
    CU_SETUP_REQ_DONE    = 10'b00_0010_0000,
    CU_SETUP_FLUSH_START = 10'b00_0100_0000,
    CU_SETUP_FLUSH_BUSY  = 10'b00_1000_0000,
    CU_SETUP_FLUSH_PAUSE = 10'b01_0000_0000,
    CU_SETUP_FLUSH_DONE  = 10'b10_0000_0000
  } cu_setup_state;

  typedef struct packed {
    logic [CU_SETUP_ADDR_MAX_W-1:0] addr;
    logic                           valid;
  } cu_setup_req_t;

  function automatic logic setup_is_busy(input cu_setup_state s);
    return !(s inside {CU_SETUP_RESET, CU_SETUP_IDLE, CU_SETUP_FLUSH_DONE});
  endfunction

endpackage

// File: rtl/cu_setup_control_credit_counter.sv
// Outstanding read-request counter with full/empty flags and a sticky
// underflow flag for responses that arrive with nothing outstanding.
module cu_setup_credit_counter #(
  parameter int MAX = 16,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          underflow
);

  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    if (inc && !dec)
      count_next = count + CW'(1);
    else if (dec && !inc && count != '0)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      count <= count_next;
      if (dec && !inc && count == '0)
        underflow <= 1'b1;
    end
  end

  assign full  = (count == CW'(MAX));
  assign empty = (count == '0);

endmodule

// File: rtl/cu_setup_control.sv
// Setup-phase sequencer: streams line reads for a descriptor region, then
// runs a flush handshake. Perf counters exist only with CU_SETUP_PERF_EN.
//
// state        | meaning
// RESET        | held in reset, leaves on first cycle after release
// IDLE         | waiting for start
// REQ_START    | load address and clear issued count
// REQ_BUSY     | presenting read requests
// REQ_PAUSE    | throttled by pause input or credits
// REQ_DONE     | all lines issued
// FLUSH_START  | one-cycle flush request to consumer
// FLUSH_BUSY   | waiting for drain and flush ack
// FLUSH_PAUSE  | held by pause input, ack still latched
// FLUSH_DONE   | done; a new start may be accepted
module cu_setup_control
  import PKG_SETUP::*;
#(
  parameter int ADDR_W          = 64,
  parameter int CNT_W           = 32,
  parameter int LINE_BYTES      = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        setup_start_in,
  input  logic [ADDR_W-1:0]           setup_base_addr_in,
  input  logic [CNT_W-1:0]            setup_num_lines_in,
  input  logic                        setup_pause_in,
  output logic                        req_valid_out,
  input  logic                        req_ready_in,
  output logic [ADDR_W-1:0]           req_addr_out,
  input  logic                        rsp_valid_in,
  output logic                        flush_req_out,
  input  logic                        flush_ack_in,
  output logic                        setup_busy_out,
  output logic                        setup_done_out,
  output logic [CU_SETUP_STATE_W-1:0] setup_state_out,
  output logic                        rsp_underflow_out,
  output logic [31:0]                 perf_busy_cycles_out,
  output logic [31:0]                 perf_pause_cycles_out
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  cu_setup_state state, state_nxt;
  cu_setup_req_t req_q;
  logic [CU_SETUP_ADDR_MAX_W-1:0] base_q;
  logic [CNT_W-1:0] lines_q, issued_q, issued_nxt;
  logic ack_q, fire, start_ok, would_fill, drained;
  logic [CW-1:0] out_cnt;
  logic out_full, out_empty;

  cu_setup_credit_counter #(.MAX(MAX_OUTSTANDING), .CW(CW)) u_credit (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .inc       (fire),
    .dec       (rsp_valid_in),
    .count     (out_cnt),
    .full      (out_full),
    .empty     (out_empty),
    .underflow (rsp_underflow_out)
  );

  assign fire       = req_q.valid && req_ready_in;
  assign start_ok   = setup_start_in && (state == CU_SETUP_IDLE || state == CU_SETUP_FLUSH_DONE);
  assign issued_nxt = issued_q + CNT_W'(fire);
  // Credits hit the limit after this edge only if a request goes out with no response back.
  assign would_fill = fire && !rsp_valid_in && (out_cnt == CW'(MAX_OUTSTANDING - 1));
  assign drained    = out_empty || (rsp_valid_in && out_cnt == CW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      CU_SETUP_RESET:       state_nxt = CU_SETUP_IDLE;
      CU_SETUP_IDLE,
      CU_SETUP_FLUSH_DONE:  if (setup_start_in) state_nxt = CU_SETUP_REQ_START;
      CU_SETUP_REQ_START:   state_nxt = (lines_q == '0) ? CU_SETUP_REQ_DONE : CU_SETUP_REQ_BUSY;
      CU_SETUP_REQ_BUSY: begin
        if (issued_nxt == lines_q)
          state_nxt = CU_SETUP_REQ_DONE;
        else if (setup_pause_in || would_fill)
          state_nxt = CU_SETUP_REQ_PAUSE;
      end
      CU_SETUP_REQ_PAUSE:   if (!setup_pause_in && !out_full) state_nxt = CU_SETUP_REQ_BUSY;
      CU_SETUP_REQ_DONE:    state_nxt = CU_SETUP_FLUSH_START;
      CU_SETUP_FLUSH_START: state_nxt = CU_SETUP_FLUSH_BUSY;
      CU_SETUP_FLUSH_BUSY: begin
        if (setup_pause_in)
          state_nxt = CU_SETUP_FLUSH_PAUSE;
        else if (drained && (ack_q || flush_ack_in))
          state_nxt = CU_SETUP_FLUSH_DONE;
      end
      CU_SETUP_FLUSH_PAUSE: if (!setup_pause_in) state_nxt = CU_SETUP_FLUSH_BUSY;
      default:              state_nxt = CU_SETUP_RESET;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state          <= CU_SETUP_RESET;
      req_q          <= '0;
      base_q         <= '0;
      lines_q        <= '0;
      issued_q       <= '0;
      ack_q          <= 1'b0;
      flush_req_out  <= 1'b0;
      setup_busy_out <= 1'b0;
      setup_done_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      req_q.valid    <= (state_nxt == CU_SETUP_REQ_BUSY);
      flush_req_out  <= (state_nxt == CU_SETUP_FLUSH_START);
      setup_busy_out <= setup_is_busy(state_nxt);
      setup_done_out <= (state_nxt == CU_SETUP_FLUSH_DONE);
      if (start_ok) begin
        base_q  <= CU_SETUP_ADDR_MAX_W'(setup_base_addr_in);
        lines_q <= setup_num_lines_in;
      end
      if (state == CU_SETUP_REQ_START) begin
        req_q.addr <= base_q;
        issued_q   <= '0;
      end else if (fire) begin
        req_q.addr <= req_q.addr + CU_SETUP_ADDR_MAX_W'(LINE_BYTES);
        issued_q   <= issued_nxt;
      end
      if (state == CU_SETUP_FLUSH_START)
        ack_q <= 1'b0;
      else if (flush_ack_in)
        ack_q <= 1'b1;
    end
  end

  assign req_valid_out   = req_q.valid;
  assign req_addr_out    = req_q.addr[ADDR_W-1:0];
  assign setup_state_out = state;

`ifdef CU_SETUP_PERF_EN
  logic [31:0] busy_cnt, pause_cnt;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || start_ok) begin
      busy_cnt  <= '0;
      pause_cnt <= '0;
    end else begin
      if (setup_busy_out && busy_cnt != '1)
        busy_cnt <= busy_cnt + 32'd1;
      if ((state == CU_SETUP_REQ_PAUSE || state == CU_SETUP_FLUSH_PAUSE) && pause_cnt != '1)
        pause_cnt <= pause_cnt + 32'd1;
    end
  end

  assign perf_busy_cycles_out  = busy_cnt;
  assign perf_pause_cycles_out = pause_cnt;
`else
  assign perf_busy_cycles_out  = '0;
  assign perf_pause_cycles_out = '0;
`endif

endmodule

// File: tb/tb_cu_setup_control.sv
// Directed bench for cu_setup_control with a two-credit limit; perf-counter
// expectations follow CU_SETUP_PERF_EN.
module tb_cu_setup_control;

  localparam logic [9:0] S_RESET = 10'h001, S_IDLE = 10'h002, S_RSTART = 10'h004,
                         S_RBUSY = 10'h008, S_RPAUSE = 10'h010, S_RDONE = 10'h020,
                         S_FSTART = 10'h040, S_FBUSY = 10'h080, S_FPAUSE = 10'h100,
                         S_FDONE = 10'h200;
`ifdef CU_SETUP_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic        ap_clk, ap_rst_n;
  logic        setup_start_in, setup_pause_in, req_ready_in, rsp_valid_in, flush_ack_in;
  logic [63:0] setup_base_addr_in;
  logic [31:0] setup_num_lines_in;
  logic        req_valid_out, flush_req_out, setup_busy_out, setup_done_out, rsp_underflow_out;
  logic [63:0] req_addr_out;
  logic [9:0]  setup_state_out;
  logic [31:0] perf_busy_cycles_out, perf_pause_cycles_out;

  int checks = 0;
  int errors = 0;
  int nreq, nflush, first_fire, last_fire, flush_idx;
  logic [63:0] addr_log [0:15];

  cu_setup_control #(.MAX_OUTSTANDING(2)) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .setup_start_in        (setup_start_in),
    .setup_base_addr_in    (setup_base_addr_in),
    .setup_num_lines_in    (setup_num_lines_in),
    .setup_pause_in        (setup_pause_in),
    .req_valid_out         (req_valid_out),
    .req_ready_in          (req_ready_in),
    .req_addr_out          (req_addr_out),
    .rsp_valid_in          (rsp_valid_in),
    .flush_req_out         (flush_req_out),
    .flush_ack_in          (flush_ack_in),
    .setup_busy_out        (setup_busy_out),
    .setup_done_out        (setup_done_out),
    .setup_state_out       (setup_state_out),
    .rsp_underflow_out     (rsp_underflow_out),
    .perf_busy_cycles_out  (perf_busy_cycles_out),
    .perf_pause_cycles_out (perf_pause_cycles_out)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic [63:0] base, input logic [31:0] lines);
    setup_start_in = 1'b1;
    setup_base_addr_in = base;
    setup_num_lines_in = lines;
    step();
    setup_start_in = 1'b0;
  endtask

  // Returns a response one cycle after each accepted request and an ack one
  // cycle after the flush request, logging what the DUT issues.
  task automatic run_auto(input int n);
    logic pf, pfl;
    pf = 1'b0;
    pfl = 1'b0;
    for (int i = 0; i < n; i++) begin
      rsp_valid_in = pf;
      flush_ack_in = pfl;
      pf = req_valid_out && req_ready_in;
      if (pf) begin
        if (nreq == 0) first_fire = i;
        last_fire = i;
        if (nreq < 16) addr_log[nreq] = req_addr_out;
        nreq++;
      end
      pfl = flush_req_out;
      if (flush_req_out) begin
        nflush++;
        flush_idx = i;
      end
      step();
    end
    rsp_valid_in = 1'b0;
    flush_ack_in = 1'b0;
  endtask

  initial begin
    ap_rst_n = 1'b0;
    setup_start_in = 1'b0;
    setup_pause_in = 1'b0;
    req_ready_in = 1'b1;
    rsp_valid_in = 1'b0;
    flush_ack_in = 1'b0;
    setup_base_addr_in = '0;
    setup_num_lines_in = '0;
    step();
    step();
    chk("rst_state", setup_state_out, S_RESET);
    chk("rst_valid", req_valid_out, 1'b0);
    chk("rst_busy", setup_busy_out, 1'b0);
    chk("rst_done", setup_done_out, 1'b0);
    chk("rst_flush", flush_req_out, 1'b0);
    chk("rst_uflow", rsp_underflow_out, 1'b0);
    ap_rst_n = 1'b1;
    step();
    chk("idle_after_rst", setup_state_out, S_IDLE);

    // response with nothing outstanding
    rsp_valid_in = 1'b1;
    step();
    rsp_valid_in = 1'b0;
    chk("uflow_set", rsp_underflow_out, 1'b1);
    chk("uflow_cnt", dut.u_credit.count, 2'd0);
    step();
    chk("uflow_sticky", rsp_underflow_out, 1'b1);

    // four lines, ready always high
    start(64'h1000, 32'd4);
    chk("t1_rstart", setup_state_out, S_RSTART);
    nreq = 0; nflush = 0; first_fire = -1; last_fire = -1; flush_idx = -1;
    run_auto(8);
    chk("t1_nreq", nreq, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_addr%0d", i), addr_log[i], 64'h1000 + 64'(i) * 64'h40);
    chk("t1_first", first_fire, 1);
    chk("t1_last", last_fire, 4);
    chk("t1_nflush", nflush, 1);
    chk("t1_flush_idx", flush_idx, 6);
    chk("t1_state", setup_state_out, S_FDONE);
    chk("t1_done", setup_done_out, 1'b1);
    chk("t1_busy", setup_busy_out, 1'b0);

    // zero lines
    start(64'h2000, 32'd0);
    chk("t2_rstart", setup_state_out, S_RSTART);
    step();
    chk("t2_rdone", setup_state_out, S_RDONE);
    chk("t2_valid", req_valid_out, 1'b0);
    step();
    chk("t2_fstart", setup_state_out, S_FSTART);
    chk("t2_flush", flush_req_out, 1'b1);
    step();
    chk("t2_fbusy", setup_state_out, S_FBUSY);
    chk("t2_flush_off", flush_req_out, 1'b0);
    step();
    chk("t2_wait_ack", setup_done_out, 1'b0);
    flush_ack_in = 1'b1;
    step();
    flush_ack_in = 1'b0;
    chk("t2_done", setup_done_out, 1'b1);

    // credit limit of two, responses withheld
    start(64'h3000, 32'd6);
    step();
    chk("t3_v0", req_valid_out, 1'b1);
    chk("t3_a0", req_addr_out, 64'h3000);
    step();
    chk("t3_a1", req_addr_out, 64'h3040);
    step();
    chk("t3_paused", setup_state_out, S_RPAUSE);
    chk("t3_novalid", req_valid_out, 1'b0);
    step();
    chk("t3_held", req_valid_out, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rsp_valid_in = 1'b1;
      step();
      rsp_valid_in = 1'b0;
      chk($sformatf("t3_gap%0d", k), req_valid_out, 1'b0);
      step();
      chk($sformatf("t3_v%0d", k + 2), req_valid_out, 1'b1);
      chk($sformatf("t3_a%0d", k + 2), req_addr_out, 64'h3080 + 64'(k) * 64'h40);
      step();
      chk($sformatf("t3_st%0d", k + 2), setup_state_out, (k < 3) ? S_RPAUSE : S_RDONE);
    end
    step();
    chk("t3_flush", flush_req_out, 1'b1);
    step();
    flush_ack_in = 1'b1;
    step();
    flush_ack_in = 1'b0;
    chk("t3_wait_rsp", setup_state_out, S_FBUSY);
    rsp_valid_in = 1'b1;
    step();
    chk("t3_one_left", setup_state_out, S_FBUSY);
    step();
    rsp_valid_in = 1'b0;
    chk("t3_done", setup_done_out, 1'b1);

    // pause for five cycles in each phase
    start(64'h4000, 32'd3);
    step();
    chk("t4_a0", req_addr_out, 64'h4000);
    setup_pause_in = 1'b1;
    step();
    chk("t4_rpause", setup_state_out, S_RPAUSE);
    chk("t4_nv0", req_valid_out, 1'b0);
    rsp_valid_in = 1'b1;
    step();
    rsp_valid_in = 1'b0;
    chk("t4_nv1", req_valid_out, 1'b0);
    step();
    chk("t4_nv2", req_valid_out, 1'b0);
    step();
    chk("t4_nv3", req_valid_out, 1'b0);
    step();
    setup_pause_in = 1'b0;
    chk("t4_nv4", req_valid_out, 1'b0);
    step();
    chk("t4_a1", req_addr_out, 64'h4040);
    chk("t4_v1", req_valid_out, 1'b1);
    step();
    chk("t4_a2", req_addr_out, 64'h4080);
    step();
    chk("t4_rdone", setup_state_out, S_RDONE);
    step();
    step();
    chk("t4_fbusy", setup_state_out, S_FBUSY);
    setup_pause_in = 1'b1;
    step();
    chk("t4_fpause", setup_state_out, S_FPAUSE);
    flush_ack_in = 1'b1;
    rsp_valid_in = 1'b1;
    step();
    flush_ack_in = 1'b0;
    step();
    rsp_valid_in = 1'b0;
    step();
    chk("t4_fpause_held", setup_state_out, S_FPAUSE);
    step();
    setup_pause_in = 1'b0;
    chk("t4_fpause_last", setup_state_out, S_FPAUSE);
    step();
    chk("t4_fbusy2", setup_state_out, S_FBUSY);
    step();
    chk("t4_done", setup_done_out, 1'b1);
    chk("t4_perf_busy", perf_busy_cycles_out, (PERF_ON != 0) ? 32'd18 : 32'd0);
    chk("t4_perf_pause", perf_pause_cycles_out, (PERF_ON != 0) ? 32'd10 : 32'd0);
    chk("t4_uflow_kept", rsp_underflow_out, 1'b1);

    // reset after three of eight requests
    start(64'h5000, 32'd8);
    nreq = 0; nflush = 0; first_fire = -1; last_fire = -1; flush_idx = -1;
    run_auto(4);
    chk("t6_nreq", nreq, 3);
    ap_rst_n = 1'b0;
    step();
    chk("t6_state", setup_state_out, S_RESET);
    chk("t6_valid", req_valid_out, 1'b0);
    chk("t6_addr", req_addr_out, 64'h0);
    chk("t6_busy", setup_busy_out, 1'b0);
    chk("t6_flush", flush_req_out, 1'b0);
    chk("t6_uflow", rsp_underflow_out, 1'b0);
    chk("t6_perf", perf_busy_cycles_out, 32'd0);
    chk("t6_cnt", dut.u_credit.count, 2'd0);
    ap_rst_n = 1'b1;
    step();
    chk("t6_idle", setup_state_out, S_IDLE);
    start(64'h6000, 32'd1);
    step();
    chk("t6_a0", req_addr_out, 64'h6000);
    chk("t6_v0", req_valid_out, 1'b1);
    step();
    rsp_valid_in = 1'b1;
    step();
    rsp_valid_in = 1'b0;
    chk("t6_fstart", flush_req_out, 1'b1);
    step();
    flush_ack_in = 1'b1;
    step();
    flush_ack_in = 1'b0;
    chk("t6_done", setup_done_out, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
